mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage multiply (ALU control code 4'b1111).
- Runs an iterative shift-add multiply over several cycles instead of one combinational multiply.
- Holds the pipeline with a stall signal while it runs, and returns the low WIDTH bits of the product with a one-cycle done pulse.
- All other ALU control codes are ignored; the single-cycle ALU keeps serving them.

Parameters:
- WIDTH, 32, operand and result width in bits; also the maximum number of iterations.
- MUL_CODE, 4'b1111, ALU control code that triggers a multiply.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  EX stage holds a valid instruction this cycle.
- ALUCtrl_i  input  4  ALU control code from the ALU controller.
- src1_i  input  WIDTH  multiplicand.
- src2_i  input  WIDTH  multiplier.
- flush_i  input  1  squash the instruction in EX (branch/jump redirect).
- stall_o  output  1  hold PC, IF/ID and ID/EX.
- busy_o  output  1  state is RUN.
- done_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  WIDTH  low WIDTH bits of src1*src2.

Behaviour:
- States: IDLE, RUN, DONE. Internal registers:
  - mcand (WIDTH): multiplicand, shifted left each iteration.
  - mplier (WIDTH): multiplier, shifted right each iteration.
  - prod (WIDTH): partial product.
  - cnt: 0..WIDTH-1.
- Reset (async, rst_i=0):
  - State goes to IDLE; cnt, prod and result_o go to 0.
  - done_o=0, busy_o=0, stall_o=0.
  - Applies immediately, including mid-RUN; no done pulse follows.
- Accept condition (IDLE): start_i=1, ALUCtrl_i==MUL_CODE and flush_i=0.
  - At the edge: latch mcand=src1_i, mplier=src2_i, prod=0, cnt=0; go to RUN.
- stall_o is combinational: (IDLE and accept condition true) or state==RUN.
  - The pipeline is frozen in the accept cycle and every RUN cycle.
  - stall_o=0 in DONE.
- RUN, each edge:
  - If mplier[0]=1, prod += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt += 1.
  - If cnt==WIDTH-1 before the increment, go to DONE.
- DONE:
  - result_o <= final prod, registered on the RUN->DONE edge.
  - done_o=1 for this cycle only; the pipeline advances and EX/MEM captures result_o.
  - Go to IDLE at the next edge.
- Latency:
  - Accept edge, then WIDTH RUN cycles, then DONE.
  - done_o is high in cycle WIDTH+1 after the accept cycle.
  - stall_o is high for exactly WIDTH+1 cycles.
- Arithmetic:
  - Result is the low WIDTH bits only, so it is two's-complement correct for signed operands.
  - Overflow wraps silently; no flags.
- result_o holds its value until the next DONE entry or reset.
- Non-MUL_CODE ALUCtrl_i with start_i=1 is ignored: stays IDLE, no stall.
- start_i while in RUN or DONE is ignored (upstream is stalled, or advancing in DONE).
- Back-to-back multiplies: a new accept is possible only in IDLE, i.e. the cycle after DONE.
- flush_i:
  - In IDLE: blocks acceptance in the same cycle.
  - In RUN: at the next edge go to IDLE; no done pulse; result_o unchanged.
  - stall_o drops combinationally once the state is IDLE.
  - In DONE: no effect (the result is already registered).
- busy_o = (state==RUN), registered-state decode with no combinational path from inputs.

Optional Feature:
- MUL_EARLY_EXIT_EN
- Defined:
  - In RUN, also go to DONE when the post-shift mplier value (mplier>>1) is 0.
  - A zero multiplier completes after 1 RUN cycle.
  - Latency becomes (index of the highest set bit of src2_i)+1 RUN cycles, minimum 1.
  - stall_o and done_o timing follow the shortened RUN.
- Not defined:
  - Always exactly WIDTH RUN cycles.
  - Early-exit logic is absent from the netlist.

Test Plan:
- Reset, then src1=7, src2=6, ALUCtrl=4'b1111, start=1 for 1 cycle
  -> stall_o high 33 cycles; done_o pulses in cycle 33; result_o=32'd42; busy_o high 32 cycles.
- src1=32'hFFFFFFFD (-3), src2=5
  -> result_o=32'hFFFFFFF1 (-15) at done.
  - With MUL_EARLY_EXIT_EN: done after 3 RUN cycles.
- src1=32'h00010000, src2=32'h00010000
  -> result_o=32'h00000000 (wrap); no error flags; full 32 RUN cycles, or 17 with the macro.
- Start a multiply, assert flush_i in RUN cycle 10
  -> next cycle: IDLE, stall_o=0, busy_o=0, no done_o; result_o keeps its previous value (42).
- start=1 with ALUCtrl=4'b0010, and separately start=1 with ALUCtrl=4'b1111 plus flush_i=1
  -> stall_o stays 0; state stays IDLE; done_o never asserts.
- Drop rst_i low in RUN cycle 5, release it, then immediately start 9*9
  -> outputs 0 during reset; no done from the aborted op; new op gives result_o=81 with full latency.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add multiply sequencer for the EX stage; stalls the pipe while running.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul_seq_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'b1111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept, last;

  assign accept = start_i && (ALUCtrl_i == MUL_CODE) && !flush_i;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (cnt_q == CW'(WIDTH-1)) || ((mplier_q >> 1) == '0);
`else
  assign last = (cnt_q == CW'(WIDTH-1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = src1_i;
          mplier_d = src2_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (last) begin
            // Result is captured from the final partial sum on the same edge.
            result_d = prod_d;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign stall_o  = ((state_q == S_IDLE) && accept) || (state_q == S_RUN);
  assign busy_o   = (state_q == S_RUN);
  assign done_o   = done_q;
  assign result_o = result_q;
endmodule
